// File: rtl/exec_cc_stage.sv
// rtl/exec_cc_stage.sv - Y86-64 execute back end: condition codes, Cnd evaluation, output slot, halt tracking
//
// Captures the ALU result into a one-entry valid/ready slot that feeds the
// memory stage. Holds the architectural condition codes and evaluates the
// jXX/cmovXX condition from them. Stops accepting instructions once a HALT
// has left this stage.
//
// Optional feature macro: EXC_STATUS_EN
//   When defined, adds out_stat (1=AOK, 2=HLT, 3=INS). Icodes above 0xB then
//   halt the stage like HALT does. When undefined, those icodes pass through
//   as NOPs.
//
// Ports:
//   clk, rst                 clock, asynchronous active-high reset
//   in_valid / in_ready      upstream handshake
//   in_icode, in_ifun        instruction and function codes
//   in_alu_ans               ALU result (valE)
//   in_alu_zf/sf/of          ALU flags
//   flush                    squash the incoming instruction and the slot
//   out_valid / out_ready    downstream handshake
//   out_icode, out_valE      registered icode and valE
//   out_cnd                  registered condition outcome
//   out_stat                 registered status (EXC_STATUS_EN only)
//   cc_zf, cc_sf, cc_of      architectural condition codes
//   halted                   stage is in HALTED state

module exec_cc_stage #(
   parameter int WORD_W  = 64,
   parameter int ICODE_W = 4
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               in_valid,
   output logic               in_ready,
   input  logic [ICODE_W-1:0] in_icode,
   input  logic [ICODE_W-1:0] in_ifun,
   input  logic [WORD_W-1:0]  in_alu_ans,
   input  logic               in_alu_zf,
   input  logic               in_alu_sf,
   input  logic               in_alu_of,
   input  logic               flush,
   output logic               out_valid,
   input  logic               out_ready,
   output logic [ICODE_W-1:0] out_icode,
   output logic [WORD_W-1:0]  out_valE,
   output logic               out_cnd,
`ifdef EXC_STATUS_EN
   output logic [1:0]         out_stat,
`endif
   output logic               cc_zf,
   output logic               cc_sf,
   output logic               cc_of,
   output logic               halted
);

   localparam logic [ICODE_W-1:0] I_HALT  = ICODE_W'(0);
   localparam logic [ICODE_W-1:0] I_NOP   = ICODE_W'(1);
   localparam logic [ICODE_W-1:0] I_CMOV  = ICODE_W'(2);
   localparam logic [ICODE_W-1:0] I_OPQ   = ICODE_W'(6);
   localparam logic [ICODE_W-1:0] I_JXX   = ICODE_W'(7);
   localparam logic [ICODE_W-1:0] I_LAST  = ICODE_W'(11);
   localparam logic [ICODE_W-1:0] F_OPMAX = ICODE_W'(3);

   typedef enum logic [1:0] {
      RUN       = 2'd0,
      HALT_PEND = 2'd1,
      HALTED    = 2'd2
   } state_t;

   state_t state;
   state_t state_next;

   logic accept;
   logic take_halt;
   logic cnd;
   logic cc_write;
   logic sf_xor_of;

   assign in_ready = (state == RUN) && (!out_valid || out_ready);
   // flush wins over a simultaneous handshake: the instruction is dropped
   assign accept   = in_valid && in_ready && !flush;
   assign cc_write = accept && (in_icode == I_OPQ) && (in_ifun <= F_OPMAX);
   assign halted   = (state == HALTED);

`ifdef EXC_STATUS_EN
   // invalid icodes retire through the same halt path as HALT
   assign take_halt = (in_icode == I_HALT) || (in_icode > I_LAST);
`else
   assign take_halt = (in_icode == I_HALT);
`endif

   // Condition is judged from the flags already in CC, not from this
   // cycle's ALU flags; an OPq ahead of a jXX has written CC one edge earlier.
   assign sf_xor_of = cc_sf ^ cc_of;
   always_comb begin
      cnd = 1'b0;
      case (in_ifun)
         ICODE_W'(0): cnd = 1'b1;
         ICODE_W'(1): cnd = sf_xor_of | cc_zf;
         ICODE_W'(2): cnd = sf_xor_of;
         ICODE_W'(3): cnd = cc_zf;
         ICODE_W'(4): cnd = ~cc_zf;
         ICODE_W'(5): cnd = ~sf_xor_of;
         ICODE_W'(6): cnd = ~sf_xor_of & ~cc_zf;
         default:     cnd = 1'b0;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= RUN;
      end else begin
         state <= state_next;
      end
   end

   always_comb begin
      state_next = state;
      case (state)
         RUN: begin
            if (accept && take_halt) begin
               state_next = HALT_PEND;
            end
         end
         HALT_PEND: begin
            // a flushed HALT was on a mispredicted path; resume normally
            if (flush) begin
               state_next = RUN;
            end else if (out_ready) begin
               state_next = HALTED;
            end
         end
         HALTED: begin
            state_next = HALTED;
         end
         default: begin
            state_next = RUN;
         end
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         out_valid <= 1'b0;
         out_icode <= I_NOP;
         out_valE  <= '0;
         out_cnd   <= 1'b0;
`ifdef EXC_STATUS_EN
         out_stat  <= 2'd1;
`endif
      end else if (flush) begin
         out_valid <= 1'b0;
      end else if (accept) begin
         out_valid <= 1'b1;
         out_icode <= in_icode;
         out_valE  <= in_alu_ans;
         out_cnd   <= ((in_icode == I_CMOV) || (in_icode == I_JXX)) ? cnd : 1'b0;
`ifdef EXC_STATUS_EN
         if (in_icode == I_HALT) begin
            out_stat <= 2'd2;
         end else if (in_icode > I_LAST) begin
            out_stat <= 2'd3;
         end else begin
            out_stat <= 2'd1;
         end
`endif
      end else if (out_ready) begin
         out_valid <= 1'b0;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cc_zf <= 1'b1;
         cc_sf <= 1'b0;
         cc_of <= 1'b0;
      end else if (cc_write) begin
         cc_zf <= in_alu_zf;
         cc_sf <= in_alu_sf;
         cc_of <= in_alu_of;
      end
   end

endmodule

// File: tb/tb_exec_cc_stage.sv
// tb/tb_exec_cc_stage.sv - directed vector bench for exec_cc_stage

module tb_exec_cc_stage;

   logic        clk = 1'b0;
   logic        rst;
   logic        in_valid;
   logic        in_ready;
   logic [3:0]  in_icode;
   logic [3:0]  in_ifun;
   logic [63:0] in_alu_ans;
   logic        in_alu_zf;
   logic        in_alu_sf;
   logic        in_alu_of;
   logic        flush;
   logic        out_valid;
   logic        out_ready;
   logic [3:0]  out_icode;
   logic [63:0] out_valE;
   logic        out_cnd;
`ifdef EXC_STATUS_EN
   logic [1:0]  out_stat;
`endif
   logic        cc_zf;
   logic        cc_sf;
   logic        cc_of;
   logic        halted;

   int n_chk  = 0;
   int n_fail = 0;

   exec_cc_stage #(.WORD_W(64), .ICODE_W(4)) dut (
      .clk        (clk),
      .rst        (rst),
      .in_valid   (in_valid),
      .in_ready   (in_ready),
      .in_icode   (in_icode),
      .in_ifun    (in_ifun),
      .in_alu_ans (in_alu_ans),
      .in_alu_zf  (in_alu_zf),
      .in_alu_sf  (in_alu_sf),
      .in_alu_of  (in_alu_of),
      .flush      (flush),
      .out_valid  (out_valid),
      .out_ready  (out_ready),
      .out_icode  (out_icode),
      .out_valE   (out_valE),
      .out_cnd    (out_cnd),
`ifdef EXC_STATUS_EN
      .out_stat   (out_stat),
`endif
      .cc_zf      (cc_zf),
      .cc_sf      (cc_sf),
      .cc_of      (cc_of),
      .halted     (halted)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic        valid;
      logic [3:0]  icode;
      logic [3:0]  ifun;
      logic [63:0] ans;
      logic [2:0]  flg;
      logic        flush;
      logic        ord;
      logic        e_rdy;
      logic        e_ov;
      logic [3:0]  e_icode;
      logic [63:0] e_valE;
      logic        e_cnd;
      logic [2:0]  e_cc;
      logic        e_halt;
   } vec_t;

   vec_t tbl [32];

   function automatic vec_t mk(input logic v, input logic [3:0] ic, input logic [3:0] fn,
                               input logic [63:0] a, input logic [2:0] f, input logic fl,
                               input logic o, input logic er, input logic eov,
                               input logic [3:0] eic, input logic [63:0] eve,
                               input logic ec, input logic [2:0] ecc, input logic eh);
      vec_t r;
      r.valid = v;  r.icode = ic;  r.ifun = fn;  r.ans = a;  r.flg = f;
      r.flush = fl; r.ord = o;     r.e_rdy = er; r.e_ov = eov;
      r.e_icode = eic; r.e_valE = eve; r.e_cnd = ec; r.e_cc = ecc; r.e_halt = eh;
      return r;
   endfunction

   function automatic logic [73:0] obs();
      return {out_valid, out_icode, out_valE, out_cnd, cc_zf, cc_sf, cc_of, halted};
   endfunction

   task automatic check(input string name, input logic [73:0] act, input logic [73:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic apply(input int i);
      vec_t v;
      v = tbl[i];
      in_valid   = v.valid;
      in_icode   = v.icode;
      in_ifun    = v.ifun;
      in_alu_ans = v.ans;
      {in_alu_zf, in_alu_sf, in_alu_of} = v.flg;
      flush      = v.flush;
      out_ready  = v.ord;
      #1;
      check($sformatf("v%0d in_ready", i), 74'(in_ready), 74'(v.e_rdy));
      @(posedge clk);
      #1;
      check($sformatf("v%0d outputs", i), obs(),
            {v.e_ov, v.e_icode, v.e_valE, v.e_cnd, v.e_cc, v.e_halt});
   endtask

   task automatic check_reset(input string name);
      check({name, " outputs"}, obs(), {1'b0, 4'h1, 64'h0, 1'b0, 3'b100, 1'b0});
      check({name, " in_ready"}, 74'(in_ready), 74'(1'b1));
   endtask

   localparam logic [63:0] ONES = 64'hFFFF_FFFF_FFFF_FFFF;

   initial begin
      //            v  ic  fn  ans      flg     fl o  rdy ov eic  evalE    cnd cc      h
      tbl[0]  = mk(1, 6,  1,  64'h0,   3'b100, 0, 1, 1,  1, 6,  64'h0,   0, 3'b100, 0);
      tbl[1]  = mk(1, 7,  3,  64'h40,  3'b000, 0, 1, 1,  1, 7,  64'h40,  1, 3'b100, 0);
      tbl[2]  = mk(1, 6,  1,  ONES,    3'b010, 0, 1, 1,  1, 6,  ONES,    0, 3'b010, 0);
      tbl[3]  = mk(1, 7,  2,  64'h80,  3'b000, 0, 1, 1,  1, 7,  64'h80,  1, 3'b010, 0);
      tbl[4]  = mk(1, 7,  5,  64'h88,  3'b000, 0, 1, 1,  1, 7,  64'h88,  0, 3'b010, 0);
      tbl[5]  = mk(1, 2,  0,  64'h1234, 3'b111, 0, 1, 1, 1, 2,  64'h1234, 1, 3'b010, 0);
      tbl[6]  = mk(1, 6,  5,  64'h55,  3'b101, 0, 1, 1,  1, 6,  64'h55,  0, 3'b010, 0);
      tbl[7]  = mk(1, 7,  1,  64'h0,   3'b000, 0, 1, 1,  1, 7,  64'h0,   1, 3'b010, 0);
      tbl[8]  = mk(1, 7,  4,  64'h8,   3'b000, 0, 1, 1,  1, 7,  64'h8,   1, 3'b010, 0);
      tbl[9]  = mk(1, 7,  6,  64'h9,   3'b000, 0, 1, 1,  1, 7,  64'h9,   0, 3'b010, 0);
      tbl[10] = mk(1, 7,  9,  64'hA,   3'b000, 0, 1, 1,  1, 7,  64'hA,   0, 3'b010, 0);
      tbl[11] = mk(1, 3,  0,  64'h99,  3'b000, 0, 1, 1,  1, 3,  64'h99,  0, 3'b010, 0);
      tbl[12] = mk(0, 6,  0,  64'h0,   3'b111, 0, 1, 1,  0, 3,  64'h99,  0, 3'b010, 0);
      tbl[13] = mk(1, 6,  0,  64'h7,   3'b000, 0, 0, 1,  1, 6,  64'h7,   0, 3'b000, 0);
      tbl[14] = mk(1, 6,  0,  64'hAA,  3'b111, 0, 0, 0,  1, 6,  64'h7,   0, 3'b000, 0);
      tbl[15] = mk(1, 6,  0,  64'hAA,  3'b111, 0, 0, 0,  1, 6,  64'h7,   0, 3'b000, 0);
      tbl[16] = mk(1, 6,  0,  64'hAA,  3'b111, 0, 0, 0,  1, 6,  64'h7,   0, 3'b000, 0);
      tbl[17] = mk(1, 6,  0,  64'hAA,  3'b111, 0, 1, 1,  1, 6,  64'hAA,  0, 3'b111, 0);
      tbl[18] = mk(1, 7,  3,  64'h1,   3'b000, 0, 1, 1,  1, 7,  64'h1,   1, 3'b111, 0);
      tbl[19] = mk(1, 7,  2,  64'h2,   3'b000, 0, 1, 1,  1, 7,  64'h2,   0, 3'b111, 0);
      tbl[20] = mk(1, 6,  1,  64'h5,   3'b000, 1, 1, 1,  0, 7,  64'h2,   0, 3'b111, 0);
      tbl[21] = mk(1, 6,  0,  64'h10,  3'b111, 0, 0, 1,  1, 6,  64'h10,  0, 3'b111, 0);
      tbl[22] = mk(0, 6,  0,  64'h0,   3'b000, 1, 0, 0,  0, 6,  64'h10,  0, 3'b111, 0);
      tbl[23] = mk(1, 0,  0,  64'h0,   3'b000, 0, 0, 1,  1, 0,  64'h0,   0, 3'b111, 0);
      tbl[24] = mk(1, 6,  0,  64'h20,  3'b000, 0, 0, 0,  1, 0,  64'h0,   0, 3'b111, 0);
      tbl[25] = mk(1, 6,  0,  64'h20,  3'b000, 0, 0, 0,  1, 0,  64'h0,   0, 3'b111, 0);
      tbl[26] = mk(1, 6,  0,  64'h20,  3'b000, 0, 1, 0,  0, 0,  64'h0,   0, 3'b111, 1);
      tbl[27] = mk(1, 6,  0,  64'h20,  3'b000, 0, 1, 0,  0, 0,  64'h0,   0, 3'b111, 1);
      tbl[28] = mk(1, 6,  0,  64'h20,  3'b000, 1, 1, 0,  0, 0,  64'h0,   0, 3'b111, 1);
      // after a reset: speculative HALT is flushed and the stage runs again
      tbl[29] = mk(1, 0,  0,  64'h0,   3'b000, 0, 0, 1,  1, 0,  64'h0,   0, 3'b100, 0);
      tbl[30] = mk(0, 0,  0,  64'h0,   3'b000, 1, 0, 0,  0, 0,  64'h0,   0, 3'b100, 0);
      tbl[31] = mk(1, 6,  1,  64'h3,   3'b010, 0, 1, 1,  1, 6,  64'h3,   0, 3'b010, 0);

      rst = 1'b1;
      in_valid = 1'b0; in_icode = 4'h1; in_ifun = 4'h0; in_alu_ans = 64'h0;
      in_alu_zf = 1'b0; in_alu_sf = 1'b0; in_alu_of = 1'b0;
      flush = 1'b0; out_ready = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      rst = 1'b0;
      #1;
      check_reset("reset");
`ifdef EXC_STATUS_EN
      check("reset out_stat", 74'(out_stat), 74'(2'd1));
`endif

      for (int i = 0; i <= 28; i++) apply(i);

      // HALTED is left only through reset
      rst = 1'b1;
      in_valid = 1'b0; flush = 1'b0; out_ready = 1'b1;
      #1;
      rst = 1'b0;
      #1;
      check_reset("halted reset");

      for (int i = 29; i <= 31; i++) apply(i);

      // async reset mid-cycle drops the in-flight slot without a clock edge
      in_valid = 1'b0;
      rst = 1'b1;
      #2;
      check("async reset", obs(), {1'b0, 4'h1, 64'h0, 1'b0, 3'b100, 1'b0});
      rst = 1'b0;
      #1;

      // icode 0xD: invalid instruction with status enabled, plain NOP otherwise
      in_valid = 1'b1; in_icode = 4'hD; in_ifun = 4'h0; in_alu_ans = 64'h77;
      {in_alu_zf, in_alu_sf, in_alu_of} = 3'b000;
      flush = 1'b0; out_ready = 1'b0;
      @(posedge clk);
      #1;
      check("icode D slot", {out_valid, out_icode, out_valE, out_cnd}, {1'b1, 4'hD, 64'h77, 1'b0});
`ifdef EXC_STATUS_EN
      check("icode D out_stat", 74'(out_stat), 74'(2'd3));
`endif
      in_valid = 1'b0; out_ready = 1'b1;
      @(posedge clk);
      #1;
`ifdef EXC_STATUS_EN
      check("icode D halted", {halted, in_ready, out_valid}, {1'b1, 1'b0, 1'b0});
`else
      check("icode D no halt", {halted, in_ready, out_valid}, {1'b0, 1'b1, 1'b0});
`endif

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule

// File: doc/exec_cc_stage.md
Name: exec_cc_stage

Overview:
- Execute-side back end of the Y86-64 datapath. Sits directly downstream of the 64-bit ALU and captures its result and flag outputs.
- Holds the architectural condition-code register (ZF/SF/OF) and evaluates the jXX/cmovXX condition (Cnd).
- Registers the instruction into a one-entry valid/ready output slot that feeds the memory stage.
- Tracks halt state so that no instruction is accepted after HALT retires from this stage.

Parameters:
- WORD_W, 64, datapath width of valE / ALU result.
- ICODE_W, 4, instruction code / function code width.

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  reset, asynchronous and active-high.
- in_valid  in  1  upstream presents an instruction.
- in_ready  out  1  stage can accept this cycle.
- in_icode  in  4  instruction code.
- in_ifun  in  4  function code.
- in_alu_ans  in  64  ALU result (valE).
- in_alu_zf  in  1  ALU zero flag.
- in_alu_sf  in  1  ALU sign flag.
- in_alu_of  in  1  ALU overflow flag.
- flush  in  1  synchronous squash of the incoming instruction and the output slot.
- out_valid  out  1  output slot holds an instruction.
- out_ready  in  1  downstream consumes this cycle.
- out_icode  out  4  registered icode.
- out_valE  out  64  registered ALU result.
- out_cnd  out  1  registered condition outcome.
- cc_zf  out  1  architectural ZF.
- cc_sf  out  1  architectural SF.
- cc_of  out  1  architectural OF.
- halted  out  1  stage is in HALTED state.

Behaviour:
- Reset (async, rst=1):
  - state=RUN, out_valid=0, out_icode=1 (NOP), out_valE=0, out_cnd=0.
  - cc_zf=1, cc_sf=0, cc_of=0.
  - halted=0.
- in_ready = (state==RUN) & (~out_valid | out_ready). This is combinational and has no dependency on in_valid.
- Accept = in_valid & in_ready & ~flush. Accepted data appears on out_* the next cycle (latency 1). Throughput is 1 per cycle while out_ready=1.
- Slot with out_valid=1 and out_ready=0: all out_* fields hold stable.
- Slot with out_ready=1 and no accept: out_valid clears next cycle.
- Cnd evaluation, combinational from the CURRENT cc_* (before any same-cycle update):
  - ifun 0 = 1.
  - ifun 1 = (SF^OF)|ZF.
  - ifun 2 = SF^OF.
  - ifun 3 = ZF.
  - ifun 4 = ~ZF.
  - ifun 5 = ~(SF^OF).
  - ifun 6 = ~(SF^OF)&~ZF.
  - ifun 7..15 = 0.
  - out_cnd captures this value only for icode 2 (rrmovq/cmovXX) and icode 7 (jXX). All other icodes capture out_cnd=0.
- CC update:
  - Occurs on an accept with icode==6 (OPq) and ifun<=3. cc_* <= in_alu_* at that edge.
  - No other icode, and no OPq with ifun>3, modifies CC.
- Back-to-back sequencing: for OPq followed by jXX, the jXX sees the flags written by the OPq, because the OPq updated CC on the prior edge.
- FSM states: RUN, HALT_PEND, HALTED.
  - RUN -> HALT_PEND: on accept of icode 0 (HALT).
  - HALT_PEND: in_ready=0. The HALT remains in the output slot.
  - HALT_PEND -> HALTED: when the HALT slot is consumed (out_ready=1).
  - HALTED: out_valid=0, in_ready=0, halted=1. Only rst leaves HALTED.
  - flush in HALT_PEND clears the slot and returns to RUN (the halt was speculative).
  - flush in HALTED has no effect.
- flush=1:
  - out_valid clears next cycle.
  - The incoming instruction is dropped, with no CC update and no FSM transition even if in_valid & in_ready.
  - flush overrides a simultaneous accept.
- rst asserted mid-operation: all state returns to reset values immediately. An in-flight slot is lost.
- valE passes through unmodified, with full 64-bit width and no sign or zero extension.

Optional Feature:
- Macro: EXC_STATUS_EN.
- Defined:
  - Adds output out_stat [1:0], registered with the slot. Encoding: 1=AOK, 2=HLT, 3=INS.
  - An accepted icode >0xB captures out_stat=3 and takes the HALT_PEND path, exactly as HALT does.
  - HALT captures out_stat=2. All other accepted icodes capture out_stat=1.
  - Reset value of out_stat is 1.
- Undefined:
  - No out_stat port.
  - icodes >0xB are treated as NOP: they pass through, cnd=0, no CC change, no halt.

Test Plan:
- Reset, then read flags -> cc_zf=1, cc_sf=0, cc_of=0, out_valid=0, in_ready=1, halted=0.
- Accept OPq subq (icode 6, ifun 1) with ans=0, zf=1, sf=0, of=0; next cycle accept jXX je (icode 7, ifun 3) -> je slot has out_cnd=1. Repeat with ans=0xFFFF_FFFF_FFFF_FFFF, sf=1, then jl (ifun 2) -> out_cnd=1 and jge (ifun 5) -> out_cnd=0.
- Hold out_ready=0 with the slot full and in_valid=1 for 3 cycles -> in_ready=0, out_valE stable; CC is unchanged even though the pending input is OPq with different flags.
- Accept cmovXX (icode 2, ifun 0) with valE=0x1234 -> out_cnd=1, out_valE=0x1234, CC unchanged. Accept OPq with ifun=5 -> CC unchanged.
- Accept HALT with out_ready=0 for 2 cycles, then out_ready=1 -> halted=1 on the following cycle and in_ready stays 0. A later flush has no effect; asserting rst returns state to RUN.
- Assert flush in the same cycle as an OPq with zf=0 while in_valid=1 and in_ready=1 -> no CC change, out_valid=0 next cycle. With EXC_STATUS_EN defined, accept icode 0xD -> out_stat=3, then HALTED.
